// File: rtl/int_to_fp_converter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : int_to_fp_converter                                         |
// | Purpose  : Converts a 32-bit signed or unsigned integer into the FPU   |
// |            float format {sign, exp[5:0] bias 31, frac[24:0]} using a   |
// |            one-bit-per-cycle normaliser followed by round-to-nearest-  |
// |            even, under a start/done handshake.                         |
// | Ports    : clock, reset      - clock, synchronous active-high reset    |
// |            start             - request, sampled only when idle         |
// |            int_in, signed_in - operand and signedness, captured on     |
// |                                the accepting edge                      |
// |            busy              - high whenever not idle                  |
// |            done              - one-cycle completion pulse              |
// |            data_out          - converted float, held until next result |
// |            status_out        - {exp==63, inexact, negative, zero}      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module int_to_fp_converter (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] int_in,
  input  logic        signed_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Exponent of a value whose MSB already sits at bit 31 (2^31, bias 31).
  localparam logic [5:0] c_EXP_INIT = 6'd62;

  state_t      state_q, state_d;
  logic [31:0] m_q, m_d;          // operand, then magnitude, then normalised
  logic [5:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        sgn_in_q, sgn_in_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  status_q, status_d;

  // Rounding datapath, only meaningful once m_q[31] is set.
  logic        w_guard;
  logic        w_sticky;
  logic        w_inc;
  logic [25:0] w_frac_sum;
  logic [5:0]  w_exp_rnd;
  logic        w_neg;

  assign w_guard    = m_q[5];
  assign w_sticky   = |m_q[4:0];
  assign w_inc      = w_guard & (w_sticky | m_q[6]);
  // A carry out of the fraction leaves its low 25 bits at zero, which is
  // exactly the renormalised fraction of 2.0 -> 1.0 with exponent + 1.
  assign w_frac_sum = {1'b0, m_q[30:6]} + {25'd0, w_inc};
  assign w_exp_rnd  = exp_q + {5'd0, w_frac_sum[25]};
  assign w_neg      = sgn_in_q & m_q[31];

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sgn_in_d = sgn_in_q;
    data_d   = data_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d      = int_in;
          sgn_in_d = signed_in;
          state_d  = S_ABS;
        end
      end
      S_ABS: begin
        sign_d = w_neg;
        // -2^31 negates to itself, which is the correct unsigned magnitude.
        m_d    = w_neg ? (~m_q + 32'd1) : m_q;
        exp_d  = c_EXP_INIT;
        if (m_q == 32'd0) begin
          sign_d   = 1'b0;
          data_d   = 32'd0;
          status_d = 4'b0001;
          state_d  = S_DONE;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (!m_q[31]) begin
          m_d   = {m_q[30:0], 1'b0};
          exp_d = exp_q - 6'd1;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        data_d   = {sign_q, w_exp_rnd, w_frac_sum[24:0]};
        status_d = {(w_exp_rnd == 6'd63), (w_guard | w_sticky), sign_q, 1'b0};
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      m_q      <= 32'd0;
      exp_q    <= 6'd0;
      sign_q   <= 1'b0;
      sgn_in_q <= 1'b0;
      data_q   <= 32'd0;
      status_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sgn_in_q <= sgn_in_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign data_out   = data_q;
  assign status_out = status_q;

endmodule
`default_nettype wire

// File: tb/tb_int_to_fp_converter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_int_to_fp_converter                                      |
// | Purpose  : Scoreboard bench for int_to_fp_converter. A driver issues   |
// |            directed and random conversions and queues the expected     |
// |            float, status and latency; a monitor compares on done.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_int_to_fp_converter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] int_in;
  logic        signed_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int_to_fp_converter dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .int_in     (int_in),
    .signed_in  (signed_in),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .status_out (status_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  st;
    logic [31:0] lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          busycnt  = 0;
  bit          hold_valid  = 1'b0;
  bit          expect_idle = 1'b0;
  logic [31:0] last_d;
  logic [3:0]  last_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: exact real-number view of the conversion. The magnitude is
  // scaled by 2^25, divided by 2^p (p = MSB position) and rounded to
  // nearest-even on the integer remainder.
  function automatic exp_t ref_model(input logic [31:0] v, input logic s);
    exp_t            r;
    bit              neg;
    longint unsigned mag, scaled, q, rem, half;
    int              p, e;
    neg = s && v[31];
    mag = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    if (mag == 0) begin
      r.d = 32'd0; r.st = 4'b0001; r.lat = 32'd2;
      return r;
    end
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    scaled = mag << 25;
    q      = scaled >> p;
    rem    = scaled - (q << p);
    half   = (p == 0) ? 64'd0 : (64'd1 << (p - 1));
    if (p > 0 && (rem > half || (rem == half && q[0]))) q++;
    e = 31 + p;
    if (q == (64'd1 << 26)) begin
      q = 64'd1 << 25;
      e++;
    end
    q     = q - (64'd1 << 25);
    r.d   = {neg, 6'(e), q[24:0]};
    r.st  = {(e == 63), (rem != 0), neg, 1'b0};
    r.lat = 32'(35 - p);
    return r;
  endfunction

  // Monitor: one sample per cycle, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    if (busy === 1'b1) busycnt++;
    if (expect_idle) begin
      chk("idle_after_done", {31'd0, busy}, 32'd0);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      expect_idle = 1'b0;
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got data 0x%0h, expected no done", data_out);
      end else begin
        e = sb.pop_front();
        chk("data_out", data_out, e.d);
        chk("status_out", {28'd0, status_out}, {28'd0, e.st});
        chk("latency", 32'(busycnt), e.lat);
      end
      busycnt     = 0;
      last_d      = data_out;
      last_st     = status_out;
      hold_valid  = 1'b1;
      expect_idle = 1'b1;
    end else if (busy !== 1'b1) begin
      busycnt = 0;
      if (hold_valid) begin
        chk("data_hold", data_out, last_d);
        chk("status_hold", {28'd0, status_out}, {28'd0, last_st});
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      $display("FAIL idle_timeout: got busy=%0b, expected 0", busy);
    end
  endtask

  // mode 0: single-cycle start; 1: start held through the conversion and a
  // second conversion (v2) lined up behind it; 2: extra start pulse in NORM.
  task automatic do_conv(input logic [31:0] v, input logic s, input bit use_exp,
                         input exp_t ex, input int mode, input logic [31:0] v2);
    int t;
    wait_idle();
    int_in = v; signed_in = s; start = 1'b1;
    sb.push_back(use_exp ? ex : ref_model(v, s));
    @(negedge clock);
    int_in = $urandom; signed_in = 1'($urandom);
    if (mode == 1) begin
      t = 0;
      while (done !== 1'b1 && t < 100) begin
        @(negedge clock);
        int_in = $urandom;
        t++;
      end
      int_in = v2; signed_in = 1'b0;
      sb.push_back(ref_model(v2, 1'b0));
      @(negedge clock);
      @(negedge clock);
      start = 1'b0;
    end else begin
      start = 1'b0;
      if (mode == 2) begin
        @(negedge clock);
        start = 1'b1; int_in = $urandom; signed_in = 1'($urandom);
        @(negedge clock);
        start = 1'b0;
      end
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [3:0] st, input int lat);
    exp_t r;
    r.d = d; r.st = st; r.lat = 32'(lat);
    return r;
  endfunction

  typedef struct {
    logic [31:0] v;
    logic        s;
    logic [31:0] d;
    logic [3:0]  st;
    int          lat;
  } dir_t;

  dir_t dirs[$];

  initial begin
    exp_t none;
    int   t;
    none  = '0;
    reset = 1'b1; start = 1'b0; int_in = 32'd0; signed_in = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_status", {28'd0, status_out}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    dirs.push_back('{32'h0000_0001, 1'b1, 32'h3E00_0000, 4'b0000, 35});
    dirs.push_back('{32'hFFFF_FFFF, 1'b1, 32'hBE00_0000, 4'b0010, 35});
    dirs.push_back('{32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0001, 2});
    dirs.push_back('{32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0001, 2});
    dirs.push_back('{32'h0000_0003, 1'b1, 32'h4100_0000, 4'b0000, 34});
    dirs.push_back('{32'h0000_0002, 1'b1, 32'h4000_0000, 4'b0000, 34});
    dirs.push_back('{32'h8000_0000, 1'b1, 32'hFC00_0000, 4'b0010, 4});
    dirs.push_back('{32'h8000_0020, 1'b0, 32'h7C00_0000, 4'b0100, 4});
    dirs.push_back('{32'h8000_0060, 1'b0, 32'h7C00_0002, 4'b0100, 4});
    dirs.push_back('{32'h7FFF_FFFF, 1'b1, 32'h7C00_0000, 4'b0100, 5});
    dirs.push_back('{32'hFFFF_FFFF, 1'b0, 32'h7E00_0000, 4'b1100, 4});
    foreach (dirs[i])
      do_conv(dirs[i].v, dirs[i].s, 1'b1, mk(dirs[i].d, dirs[i].st, dirs[i].lat), 0, 32'd0);

    // Protocol: held start, and a stray start while normalising.
    do_conv(32'h0000_1234, 1'b0, 1'b0, none, 1, 32'h00AB_CDEF);
    do_conv(32'h0000_00FF, 1'b1, 1'b0, none, 2, 32'd0);

    // Reset during NORM: input 1, reset sampled on edge 10.
    wait_idle();
    int_in = 32'd1; signed_in = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    hold_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_data", data_out, 32'd0);
    chk("midrst_status", {28'd0, status_out}, 32'd0);
    do_conv(32'd2, 1'b1, 1'b1, mk(32'h4000_0000, 4'b0000, 34), 0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] v;
      logic        s;
      int          mode;
      v    = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      s    = 1'($urandom);
      mode = (i % 7 == 3) ? 1 : ((i % 5 == 2) ? 2 : 0);
      if (mode == 2) begin
        v = (v >> 2) | 32'd1;
        s = 1'b0;
      end
      do_conv(v, s, 1'b0, none, mode, $urandom >> $urandom_range(0, 31));
    end

    t = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
